// File: rtl/muldiv_seq.sv
// Iterative 16-bit unsigned MUL/MULH/DIVU/REMU sequencer for the EX stage.
// A shift-add multiplier and restoring divider share one WIDTH+1 bit adder.
module muldiv_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero,
  output logic             stall
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc, acc_nxt;   // multiply high half / divide remainder
  logic [WIDTH-1:0] lo, lo_nxt;     // multiply low half / divide quotient
  logic [CNT_W-1:0] cnt;

  logic             accept, div0, last;
  logic [WIDTH:0]   r_sh, add_a, add_b;
  logic             add_cin;
  logic [WIDTH+1:0] add_sum;
  logic [WIDTH-1:0] q_sh;

  // The restored remainder is always below the divisor, so WIDTH bits hold it;
  // only the shifted trial value needs the extra bit.
  always_comb begin
    accept  = (state == IDLE) && start && !flush;
    div0    = accept && op[1] && (b == '0);
    last    = (cnt == CNT_W'(WIDTH - 1));
    r_sh    = {acc, lo[WIDTH-1]};
    q_sh    = {lo[WIDTH-2:0], 1'b0};
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (op_r[1]) begin
      add_a   = r_sh;
      add_b   = ~{1'b0, b_r};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, acc};
      add_b   = lo[0] ? {1'b0, b_r} : '0;
      add_cin = 1'b0;
    end
    add_sum = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};

    acc_nxt = acc;
    lo_nxt  = lo;
    if (op_r[1]) begin
      if (add_sum[WIDTH+1]) begin
        acc_nxt = add_sum[WIDTH-1:0];
        lo_nxt  = {q_sh[WIDTH-1:1], 1'b1};
      end else begin
        acc_nxt = r_sh[WIDTH-1:0];
        lo_nxt  = q_sh;
      end
    end else begin
      acc_nxt = add_sum[WIDTH:1];
      lo_nxt  = {add_sum[0], lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = div0 ? DONE : RUN;
      RUN: begin
        if (flush)     state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      div_zero <= 1'b0;
      op_r     <= '0;
      b_r      <= '0;
      acc      <= '0;
      lo       <= '0;
      cnt      <= '0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            op_r <= op;
            b_r  <= b;
            acc  <= '0;
            lo   <= a;
            cnt  <= '0;
            if (div0) begin
              result   <= op[0] ? a : '1;
              div_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!flush) begin
            acc <= acc_nxt;
            lo  <= lo_nxt;
            cnt <= cnt + CNT_W'(1);
            if (last) begin
              // op[0] picks the high/remainder half for MULH and REMU
              result   <= op_r[0] ? acc_nxt : lo_nxt;
              div_zero <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign stall = busy | accept;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle iterative multiply/divide sequencer in the EX stage, beside the single-cycle ALU.
- Handles 16-bit unsigned MUL (low half), MULH (high half), DIVU and REMU.
- Uses one bit-serial datapath: a shift-add multiplier and a restoring divider sharing one 17-bit adder.
- Owns the start/busy/done handshake and the stall to the pipeline; holds the EX instruction until the result is ready.

Parameters:
- WIDTH, 16, operand/result width; the iteration count equals WIDTH.
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation: 00 MUL, 01 MULH, 10 DIVU, 11 REMU; sampled with start.
- a  in  WIDTH  multiplicand / dividend; sampled with start.
- b  in  WIDTH  multiplier / divisor; sampled with start.
- flush  in  1  kill the in-flight operation (branch mispredict or exception).
- busy  out  1  registered; 1 in RUN.
- done  out  1  registered; 1 for exactly one cycle in DONE.
- result  out  WIDTH  registered; valid while done=1, holds until the next done.
- div_zero  out  1  registered; qualifies result, valid with done.
- stall  out  1  combinational: busy | (state==IDLE & start & ~flush).

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, done=0, result=0, div_zero=0, counter=0, internal registers=0.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start & ~flush & ~(op[1] & b==0). Latch op, a, b. Counter=0.
  - IDLE -> DONE on start & ~flush & op[1] & b==0 (divide by zero, no iterations).
  - RUN: one iteration per cycle; counter increments. RUN -> DONE when counter==WIDTH-1 and that iteration completes.
  - DONE -> IDLE unconditionally after one cycle.
- Latency:
  - Start sampled at edge 0.
  - busy=1 in cycles 1..WIDTH.
  - done=1 in cycle WIDTH+1 (17 for WIDTH=16).
  - Divide-by-zero: done in cycle 1.
- Multiply (op[1]=0):
  - 2*WIDTH product register P={hi,lo}; init hi=0, lo=a.
  - Per iteration: sum = hi + (lo[0] ? b : 0) with carry-out c; P = {c, sum, lo} >> 1.
  - Result: MUL -> lo; MULH -> hi. Unsigned; no overflow flag.
- Divide (op[1]=1):
  - Remainder R (WIDTH+1 bits) = 0; quotient Q = a.
  - Per iteration: shift {R,Q} left by 1; trial = R - b.
    - trial >= 0: R = trial, Q[0] = 1.
    - trial < 0: restore R, Q[0] = 0.
  - Result: DIVU -> Q; REMU -> R[WIDTH-1:0].
- Divide by zero: DIVU result = all ones; REMU result = a; div_zero=1. div_zero=0 for all other completions.
- Flush:
  - In RUN: next state IDLE, busy=0, no done. result and div_zero keep their previous values.
  - In DONE: done still clears next cycle (same as normal); the consumer must ignore it.
  - flush with start in IDLE: start is not accepted and stall=0.
- start while in RUN or DONE is ignored, with no queueing. The requester keeps start high while stalled, so the op is re-sampled on return to IDLE. The pipeline must drop start once done is seen.
- a, b and op changing after acceptance have no effect.
- reset in RUN: immediate IDLE, all outputs zero.

Test Plan:
- MUL a=0x0123 b=0x0045 -> done at cycle 17, result=0x4E6F, div_zero=0; busy=1 cycles 1..16, stall=1 cycles 0..16.
- MULH a=0xFFFF b=0xFFFF -> result=0xFFFE. Then MUL with the same operands -> result=0x0001.
- DIVU a=0x03E8 b=0x0007 -> result=0x008E. REMU with the same operands -> result=0x0006. Also DIVU a=0x0005 b=0x0009 -> result=0x0000, and REMU -> 0x0005.
- DIVU a=0x1234 b=0 -> done at cycle 1, result=0xFFFF, div_zero=1. REMU a=0x1234 b=0 -> result=0x1234.
- Start a MUL, assert flush at cycle 5 -> busy=0 at cycle 6, no done, result unchanged. A new DIVU accepted at cycle 6 completes correctly at cycle 23.
- Hold start high with changing operands during RUN -> the second request is not accepted until IDLE. Assert rst at cycle 8 -> all outputs 0 immediately, state IDLE.
